// File: rtl/decim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// decim_ctrl_pkg
// Shared definitions for the decimation-chain controller:
//   state_t      - controller FSM encoding (also exported on o_state for debug)
//   DEF_RATIO    - CIC decimation ratio loaded at reset
//   MIN_RATIO    - smallest ratio the phase counter can run with
//   clamp_ratio  - maps a requested ratio onto the legal range
// -----------------------------------------------------------------------------
package decim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WARM  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int unsigned DEF_RATIO = 64;
    localparam int unsigned MIN_RATIO = 2;

    // Ratios 0 and 1 would leave no room for a one-cycle nd strobe between
    // wraps, so they are raised to the minimum.
    function automatic int unsigned clamp_ratio(input int unsigned r);
        return (r < MIN_RATIO) ? MIN_RATIO : r;
    endfunction

endpackage

// File: rtl/decim_ctrl_if.sv
// -----------------------------------------------------------------------------
// decim_ctrl_if
// Control bundle between the decimation controller and the filter chain.
//   clr       - synchronous clear for integrator/comb/ISOP/half-band stages
//   ce_int    - integrator / input-conversion clock enable
//   nd        - CIC decimation strobe (one cycle)
//   hb_ph     - half-band polyphase select
//   out_valid - Filter_out word valid
//   out_ready - downstream accepts the word
//   overrun   - sticky lost-word flag
// master: the controller; slave: the filter chain / output consumer.
// -----------------------------------------------------------------------------
interface decim_ctrl_if;

    logic clr;
    logic ce_int;
    logic nd;
    logic hb_ph;
    logic out_valid;
    logic out_ready;
    logic overrun;

    modport master (
        output clr, ce_int, nd, hb_ph, out_valid, overrun,
        input  out_ready
    );

    modport slave (
        input  clr, ce_int, nd, hb_ph, out_valid, overrun,
        output out_ready
    );

endinterface

// File: rtl/decim_ctrl_phase_cnt.sv
// -----------------------------------------------------------------------------
// decim_ctrl_phase_cnt
// Ratio counter for the CIC decimator plus half-band phase generation.
// Ports:
//   i_clk, i_rst_n - chain clock, asynchronous active-low reset
//   i_run          - count enable; when low the counter and phase are held at 0
//   i_ratio        - decimation ratio R (>= 2)
//   o_nd           - high while the counter sits at R-1
//   o_hb_ph        - toggles on every nd, 0 whenever counting restarts
//   o_hb_evt       - half-band event: nd while hb_ph is 1
// -----------------------------------------------------------------------------
module decim_ctrl_phase_cnt #(
    parameter int RATIO_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic [RATIO_W-1:0] i_ratio,
    output logic               o_nd,
    output logic               o_hb_ph,
    output logic               o_hb_evt
);

    logic [RATIO_W-1:0] r_cnt;
    logic               r_hb_ph;
    logic               w_wrap;

    // Ratio is at least 2 and the counter idles at 0, so no nd is seen while
    // the counter is held.
    assign w_wrap = (r_cnt == (i_ratio - RATIO_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_hb_ph <= 1'b0;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_hb_ph <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_hb_ph <= ~r_hb_ph;
        end else begin
            r_cnt   <= r_cnt + RATIO_W'(1);
        end
    end

    assign o_nd     = w_wrap;
    assign o_hb_ph  = r_hb_ph;
    assign o_hb_evt = w_wrap & r_hb_ph;

endmodule

// File: rtl/decim_ctrl.sv
// -----------------------------------------------------------------------------
// decim_ctrl
// Sequencer for the CIC + half-band decimation chain: flushes the chain on
// start, discards the warm-up output events, then hands output words to the
// downstream consumer with a valid/ready handshake and a sticky overrun flag.
// Ports:
//   i_clk        - chain clock (only clock)
//   i_rst_n      - asynchronous active-low reset
//   i_en         - run enable (PLL locked and system enable)
//   i_cfg_load   - load i_ratio_in into the ratio register (IDLE only)
//   i_ratio_in   - requested CIC decimation ratio
//   o_cfg_err    - one-cycle pulse when a cfg_load is rejected
//   o_state      - current FSM state (debug)
//   chain        - decim_ctrl_if master: clr, ce_int, nd, hb_ph, out_valid,
//                  overrun out; out_ready in
// -----------------------------------------------------------------------------
module decim_ctrl
    import decim_ctrl_pkg::*;
#(
    parameter int RATIO_W   = 8,
    parameter int FLUSH_CYC = 4,
    parameter int WARMUP    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_cfg_load,
    input  logic [RATIO_W-1:0] i_ratio_in,
    output logic               o_cfg_err,
    output logic [1:0]         o_state,
    decim_ctrl_if.master       chain
);

    localparam int FL_W = $clog2(FLUSH_CYC + 1);
    localparam int WU_W = $clog2(WARMUP + 1);

    state_t             r_state;
    state_t             w_state_nx;
    logic [FL_W-1:0]    r_flush_cnt;
    logic [WU_W-1:0]    r_warm_cnt;
    logic [RATIO_W-1:0] r_ratio;
    logic               r_out_valid;
    logic               r_overrun;
    logic               r_cfg_err;

    logic               w_run;
    logic               w_cnt_en;
    logic               w_nd;
    logic               w_hb_ph;
    logic               w_hb_evt;

    assign w_run    = (r_state == ST_WARM) || (r_state == ST_RUN);
    // Dropping en clears the phase counter on the same edge that returns the
    // FSM to IDLE; entering WARM starts the counter from 0.
    assign w_cnt_en = w_run && i_en;

    decim_ctrl_phase_cnt #(
        .RATIO_W (RATIO_W)
    ) u_phase_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (w_cnt_en),
        .i_ratio  (r_ratio),
        .o_nd     (w_nd),
        .o_hb_ph  (w_hb_ph),
        .o_hb_evt (w_hb_evt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (!i_en) begin
            w_state_nx = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  w_state_nx = ST_FLUSH;
                ST_FLUSH: begin
                    if (r_flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                        w_state_nx = ST_WARM;
                    end
                end
                ST_WARM: begin
                    // The WARMUP-th event itself is still discarded.
                    if (w_hb_evt && (r_warm_cnt == WU_W'(WARMUP - 1))) begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_RUN:   w_state_nx = ST_RUN;
                default:  w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush_cnt <= '0;
            r_warm_cnt  <= '0;
        end else begin
            if (r_state != ST_FLUSH) begin
                r_flush_cnt <= '0;
            end else begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end
            if ((r_state != ST_WARM) || !i_en) begin
                r_warm_cnt <= '0;
            end else if (w_hb_evt) begin
                r_warm_cnt <= r_warm_cnt + WU_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio     <= RATIO_W'(DEF_RATIO);
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_load && (r_state != ST_IDLE);
            if (i_cfg_load && (r_state == ST_IDLE)) begin
                r_ratio <= RATIO_W'(clamp_ratio(32'(i_ratio_in)));
            end

            // A fresh start forgets any word lost in the previous run.
            if ((r_state == ST_IDLE) && i_en) begin
                r_overrun <= 1'b0;
            end

            if (!i_en) begin
                r_out_valid <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (w_hb_evt) begin
                    // New word replaces the pending one; it is only lost if
                    // the pending one was not taken in this same cycle.
                    r_out_valid <= 1'b1;
                    if (r_out_valid && !chain.out_ready) begin
                        r_overrun <= 1'b1;
                    end
                end else if (r_out_valid && chain.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign chain.clr       = (r_state == ST_FLUSH);
    assign chain.ce_int    = w_run;
    assign chain.nd        = w_nd;
    assign chain.hb_ph     = w_hb_ph;
    assign chain.out_valid = r_out_valid;
    assign chain.overrun   = r_overrun;
    assign o_cfg_err       = r_cfg_err;
    assign o_state         = r_state;

endmodule

// File: tb/tb_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decim_ctrl
// Directed bench for decim_ctrl (RATIO_W=8, FLUSH_CYC=4, WARMUP=3).
// Cycle indices in comments count clock edges from the first WARM cycle (0).
// -----------------------------------------------------------------------------
module tb_decim_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_load;
    logic [7:0] ratio_in;
    logic       cfg_err;
    logic [1:0] state;

    int n_chk;
    int n_err;
    int n;

    decim_ctrl_if chain ();

    decim_ctrl #(
        .RATIO_W   (8),
        .FLUSH_CYC (4),
        .WARMUP    (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_cfg_load (cfg_load),
        .i_ratio_in (ratio_in),
        .o_cfg_err  (cfg_err),
        .o_state    (state),
        .chain      (chain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return chain.nd;
            1:       return chain.out_valid;
            default: return (state == 2'd3);
        endcase
    endfunction

    // Ticks until the selected signal is seen high; n returns the tick count
    // (equal to budget if it never rose, which the following check catches).
    task automatic wait_hi(input int sel, input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!sig(sel) && (cnt < budget));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},    32'(state),           0);
        chk({tag, "_clr"},      32'(chain.clr),       0);
        chk({tag, "_ce_int"},   32'(chain.ce_int),    0);
        chk({tag, "_nd"},       32'(chain.nd),        0);
        chk({tag, "_hb_ph"},    32'(chain.hb_ph),     0);
        chk({tag, "_out_vld"},  32'(chain.out_valid), 0);
        chk({tag, "_overrun"},  32'(chain.overrun),   0);
        chk({tag, "_cfg_err"},  32'(cfg_err),         0);
    endtask

    initial begin
        n_chk           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        en              = 1'b0;
        cfg_load        = 1'b0;
        ratio_in        = 8'd0;
        chain.out_ready = 1'b1;

        // ---- reset state, default ratio 64 ----
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_no_en", 32'(state), 0);

        en = 1'b1;
        tick();
        chk("flush_state", 32'(state), 1);
        chk("flush_clr1", 32'(chain.clr), 1);
        chk("flush_ce0", 32'(chain.ce_int), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_clr", 32'(chain.clr), 1);
        end
        tick();
        chk("warm_state", 32'(state), 2);
        chk("warm_clr0", 32'(chain.clr), 0);
        chk("warm_ce1", 32'(chain.ce_int), 1);
        chk("warm_hb0", 32'(chain.hb_ph), 0);

        wait_hi(0, 200, n);                       // nd at index 63
        chk("r64_first_nd", 32'(n), 63);
        tick();
        chk("r64_nd_width", 32'(chain.nd), 0);
        chk("r64_hb_toggle", 32'(chain.hb_ph), 1);
        wait_hi(2, 600, n);                       // RUN at 6R = 384
        chk("r64_run_entry", 32'(n), 320);
        wait_hi(1, 300, n);                       // first kept event 511 -> 512
        chk("r64_first_out", 32'(n), 128);
        tick();
        chk("r64_accept", 32'(chain.out_valid), 0);

        // ---- ratio 8 ----
        en = 1'b0;
        tick();
        chk("stop_state", 32'(state), 0);
        chk("stop_ce", 32'(chain.ce_int), 0);
        cfg_load = 1'b1;
        ratio_in = 8'd8;
        tick();
        cfg_load = 1'b0;
        chk("load8_noerr", 32'(cfg_err), 0);
        en = 1'b1;
        tick();
        chk("r8_flush", 32'(state), 1);
        repeat (4) tick();
        chk("r8_warm", 32'(state), 2);
        wait_hi(0, 50, n);
        chk("r8_first_nd", 32'(n), 7);
        wait_hi(0, 50, n);
        chk("r8_nd_period", 32'(n), 8);
        wait_hi(1, 100, n);                       // index 15 -> 64
        chk("r8_first_out", 32'(n), 49);
        chk("r8_in_run", 32'(state), 3);
        wait_hi(1, 100, n);                       // 64 -> 80
        chk("r8_out_period", 32'(n), 16);

        // ---- handshake: simultaneous event+accept, then overrun ----
        chain.out_ready = 1'b0;
        repeat (15) tick();                       // index 95: event cycle
        chk("hold_vld", 32'(chain.out_valid), 1);
        chk("evt95_nd", 32'(chain.nd), 1);
        chk("evt95_hb", 32'(chain.hb_ph), 1);
        chain.out_ready = 1'b1;
        tick();                                   // 96
        chk("sim_acc_vld", 32'(chain.out_valid), 1);
        chk("sim_acc_ovr", 32'(chain.overrun), 0);
        chain.out_ready = 1'b0;
        repeat (16) tick();                       // 112
        chk("ovr1_vld", 32'(chain.out_valid), 1);
        chk("ovr1_flag", 32'(chain.overrun), 1);
        repeat (16) tick();                       // 128
        chk("ovr2_vld", 32'(chain.out_valid), 1);
        chk("ovr2_flag", 32'(chain.overrun), 1);
        chain.out_ready = 1'b1;
        tick();                                   // 129
        chk("ovr_drain_vld", 32'(chain.out_valid), 0);
        chk("ovr_sticky", 32'(chain.overrun), 1);

        // ---- cfg_load outside IDLE ----
        cfg_load = 1'b1;
        ratio_in = 8'd1;
        tick();
        chk("cfg_err_pulse", 32'(cfg_err), 1);
        cfg_load = 1'b0;
        tick();
        chk("cfg_err_clear", 32'(cfg_err), 0);
        wait_hi(0, 50, n);                        // 131 -> 135
        chk("rej_nd_phase", 32'(n), 4);
        wait_hi(0, 50, n);                        // 135 -> 143 (event)
        chk("rej_nd_period", 32'(n), 8);

        // ---- en drop in RUN, on an event cycle ----
        en = 1'b0;
        tick();
        chk("drop_state", 32'(state), 0);
        chk("drop_ce", 32'(chain.ce_int), 0);
        chk("drop_vld", 32'(chain.out_valid), 0);
        chk("drop_hb", 32'(chain.hb_ph), 0);
        chk("drop_ovr_kept", 32'(chain.overrun), 1);

        // ---- ratio 1 clamps to 2, restart clears overrun ----
        cfg_load = 1'b1;
        ratio_in = 8'd1;
        tick();
        cfg_load = 1'b0;
        chk("load1_noerr", 32'(cfg_err), 0);
        en = 1'b1;
        tick();
        chk("r2_flush", 32'(state), 1);
        chk("r2_ovr_clr", 32'(chain.overrun), 0);
        repeat (4) tick();
        chk("r2_warm", 32'(state), 2);
        wait_hi(0, 20, n);
        chk("r2_first_nd", 32'(n), 1);
        wait_hi(0, 20, n);
        chk("r2_nd_period", 32'(n), 2);
        wait_hi(2, 50, n);                        // index 3 -> RUN at 12
        chk("r2_run_entry", 32'(n), 9);

        // ---- async reset mid-RUN ----
        chain.out_ready = 1'b0;
        wait_hi(1, 50, n);                        // event 15 -> valid at 16
        chk("r2_first_out", 32'(n), 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        en = 1'b0;
        chain.out_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle1", 32'(state), 0);
        tick();
        chk("post_rst_idle2", 32'(state), 0);
        en = 1'b1;
        tick();
        chk("post_rst_flush", 32'(state), 1);
        repeat (4) tick();
        chk("post_rst_warm", 32'(state), 2);
        wait_hi(0, 200, n);
        chk("post_rst_r64", 32'(n), 63);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decim_ctrl.md
DECIM_CTRL -- requirements
Module: decim_ctrl

Interface
REQ-001 Parameter RATIO_W, default 8: width of the decimation-ratio input.
REQ-002 Parameter FLUSH_CYC, default 4: number of cycles clr stays asserted in FLUSH.
REQ-003 Parameter WARMUP, default 3: number of half-band output events discarded after start.
REQ-004 Port clk  in  1: chain clock (512 kHz divided clock); the only clock.
REQ-005 Port rst  in  1: asynchronous, active-low reset.
REQ-006 Port en  in  1: run enable, driven by PLL locked and the system enable.
REQ-007 Port cfg_load  in  1: loads ratio_in into the ratio register.
REQ-008 Port ratio_in  in  RATIO_W: requested CIC decimation ratio R.
REQ-009 Port clr  out  1: synchronous clear for integrator, comb, ISOP and half-band stages.
REQ-010 Port ce_int  out  1: integrator/input-conversion clock enable.
REQ-011 Port nd  out  1: CIC decimation strobe to comb and ISOP, one cycle wide.
REQ-012 Port hb_ph  out  1: half-band polyphase select.
REQ-013 Port out_valid  out  1: Filter_out word valid.
REQ-014 Port out_ready  in  1: downstream accepts the word.
REQ-015 Port overrun  out  1: sticky flag for a lost output word.
REQ-016 Port cfg_err  out  1: one-cycle pulse when cfg_load is rejected.
REQ-017 Port state  out  2: current FSM state, for debug.

Function
REQ-018 FSM states: IDLE=0, FLUSH=1, WARM=2, RUN=3.
REQ-019 IDLE->FLUSH on en=1.
REQ-020 FLUSH->WARM after FLUSH_CYC cycles; clr=1 throughout FLUSH only.
REQ-021 WARM->RUN on the cycle of the WARMUP-th half-band event (hb_ph=1 && nd).
REQ-022 Any state->IDLE the cycle after en=0; same cycle, clear counters, hb_ph, out_valid.
REQ-023 ce_int=1 exactly in WARM and RUN.
REQ-024 Phase counter runs only in WARM/RUN: counts 0..R-1, wraps to 0; nd=1 when counter==R-1.
REQ-025 Phase counter is cleared to 0 on entry to WARM, so the first nd is R cycles after WARM entry.
REQ-026 hb_ph toggles on every nd; it is 0 at WARM entry.
REQ-027 Half-band event = nd && hb_ph==1 (every 2R cycles).
REQ-028 In RUN, a half-band event sets out_valid=1 on the next cycle.
REQ-029 out_valid clears the cycle after out_valid && out_ready.
REQ-030 If a half-band event occurs while out_valid=1 && out_ready=0: set overrun, keep out_valid=1.
REQ-031 Simultaneous event and accept (out_valid && out_ready): no overrun; out_valid stays 1 (new word).
REQ-032 overrun clears only on reset or on IDLE->FLUSH.
REQ-033 cfg_load accepted only in IDLE; ratio loads the next cycle.
REQ-034 Loaded ratio values 0 and 1 are clamped to 2.
REQ-035 cfg_load outside IDLE: ratio unchanged, cfg_err=1 for one cycle.
REQ-036 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-037 While rst=0, all outputs and registers are 0 except the ratio register, which is 64; state=IDLE.
REQ-038 Reset asserted mid-operation aborts immediately (asynchronously).
REQ-039 After reset release, the block resumes from IDLE only via en.

Structure
REQ-040 Shared package holds the state encoding constants, default ratio 64, and minimum ratio 2.
REQ-041 Sub-module phase_cnt (ratio counter plus nd/hb_ph generation) is natural; FSM and handshake stay in decim_ctrl.

Verification
REQ-042 Reset, ratio default, en=1 -> clr high for 4 cycles, first nd 64 cycles after WARM entry, RUN after the 3rd half-band event.
REQ-043 cfg_load with ratio_in=8 in IDLE -> nd every 8 cycles, half-band event every 16, out_valid every 16 with out_ready=1.
REQ-044 cfg_load with ratio_in=1 -> nd period 2; cfg_load in RUN -> cfg_err pulse, period unchanged.
REQ-045 RUN with out_ready held 0 across two events -> out_valid stays 1, overrun=1 sticky until next start.
REQ-046 en dropped in RUN -> state=IDLE, out_valid=0, ce_int=0 next cycle; re-enable -> full FLUSH/WARM sequence repeats.
REQ-047 Async rst pulse mid-RUN -> all outputs 0 immediately, with no clock edge required.
